// File: rtl/nibble_pkg.sv
// Shared constants and FSM state type for the nibble packer.
package nibble_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FLUSH_PEND
    } state_e;

endpackage

// File: rtl/nibble_packer.sv
// Packs pairs of 4-bit nibbles into bytes behind a valid/ready output register.
// A flush emits a lone held nibble zero-padded.
module nibble_packer
    import nibble_pkg::*;
#(
    parameter bit          HI_FIRST = 1'b1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_nib,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_padded,
    output logic [CNT_W-1:0]  byte_cnt
);

    state_e             state_q, state_d;
    logic [NIB_W-1:0]   hold_q, hold_d;
    logic               out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]  out_byte_q, out_byte_d;
    logic               out_padded_q, out_padded_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

    logic               slot_free;
    logic               in_xfer;
    logic               out_xfer;
    logic               load;
    logic               load_pad;
    logic [BYTE_W-1:0]  full_byte;
    logic [BYTE_W-1:0]  pad_byte;

    // Output slot can take a new byte if empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign in_xfer   = in_valid && in_ready;

    assign full_byte = HI_FIRST ? {hold_q, in_nib} : {in_nib, hold_q};
    assign pad_byte  = HI_FIRST ? {hold_q, 4'h0} : {4'h0, hold_q};

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        in_ready = 1'b0;
        load     = 1'b0;
        load_pad = 1'b0;
        unique case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_xfer) begin
                    hold_d  = in_nib;
                    state_d = HALF;
                end
            end
            HALF: begin
                in_ready = slot_free;
                if (in_xfer) begin
                    load    = 1'b1;
                    state_d = EMPTY;
                end else if (flush) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        load_pad = 1'b1;
                        state_d  = EMPTY;
                    end else begin
                        state_d = FLUSH_PEND;
                    end
                end
            end
            FLUSH_PEND: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_pad = 1'b1;
                    state_d  = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        out_padded_d = out_padded_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_byte_d   = load_pad ? pad_byte : full_byte;
            out_padded_d = load_pad;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        byte_cnt_d = out_xfer ? byte_cnt_q + CNT_W'(1) : byte_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= '0;
            out_padded_q <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_padded_q <= out_padded_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign out_padded = out_padded_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench: three packer instances (default, low-nibble-first, 2-bit counter)
// share one stimulus stream and are checked against hand-computed values.
module tb_nibble_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_nib;
    logic       flush;
    logic       out_ready;

    logic       in_ready, out_valid, out_padded;
    logic [7:0] out_byte, cnt;
    logic       lo_in_ready, lo_out_valid, lo_out_padded;
    logic [7:0] lo_out_byte, lo_cnt;
    logic       c2_in_ready, c2_out_valid, c2_out_padded;
    logic [7:0] c2_out_byte;
    logic [1:0] c2_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_packer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_nib(in_nib), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_padded(out_padded), .byte_cnt(cnt)
    );

    nibble_packer #(.HI_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lo_in_ready),
        .in_nib(in_nib), .flush(flush), .out_valid(lo_out_valid), .out_ready(out_ready),
        .out_byte(lo_out_byte), .out_padded(lo_out_padded), .byte_cnt(lo_cnt)
    );

    nibble_packer #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
        .in_nib(in_nib), .flush(flush), .out_valid(c2_out_valid), .out_ready(out_ready),
        .out_byte(c2_out_byte), .out_padded(c2_out_padded), .byte_cnt(c2_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; samples and drives happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] nib);
        in_valid = 1'b1;
        in_nib   = nib;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_nib = 4'h0; flush = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'h00);
        check("rst_cnt", 32'(cnt), 32'd0);
        #19 rst_n = 1'b1;
        tick();

        // A then 5, sink always ready
        send(4'hA);
        send(4'h5);
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_byte", 32'(out_byte), 32'hA5);
        check("a5_pad", 32'(out_padded), 32'd0);
        check("lo_5a_byte", 32'(lo_out_byte), 32'h5A);
        in_valid = 1'b0;
        tick();
        check("a5_cnt", 32'(cnt), 32'd1);
        check("a5_c2_cnt", 32'(c2_cnt), 32'd1);
        check("a5_drained", 32'(out_valid), 32'd0);

        // Back-pressure: A,5,C,3 with sink stalled
        out_ready = 1'b0;
        send(4'hA);
        send(4'h5);
        send(4'hC);
        check("bp_half_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_byte", 32'(out_byte), 32'hA5);
        in_nib = 4'h3;
        tick();
        check("bp_stable_byte", 32'(out_byte), 32'hA5);
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_c3_byte", 32'(out_byte), 32'hC3);
        check("bp_lo_3c_byte", 32'(lo_out_byte), 32'h3C);
        check("bp_c3_valid", 32'(out_valid), 32'd1);
        check("bp_cnt_after_a5", 32'(cnt), 32'd2);
        in_valid = 1'b0;
        tick();
        check("bp_cnt", 32'(cnt), 32'd3);
        check("bp_c2_cnt", 32'(c2_cnt), 32'd3);

        // Flush with free slot
        send(4'h3);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_byte", 32'(out_byte), 32'h30);
        check("fl_pad", 32'(out_padded), 32'd1);
        check("fl_lo_byte", 32'(lo_out_byte), 32'h03);
        tick();
        check("fl_cnt", 32'(cnt), 32'd4);
        check("fl_c2_wrap", 32'(c2_cnt), 32'd0);

        // Flush with busy slot goes pending
        out_ready = 1'b0;
        send(4'h1);
        send(4'h2);
        send(4'h3);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fp_in_ready", 32'(in_ready), 32'd0);
        check("fp_old_byte", 32'(out_byte), 32'h12);
        tick();
        check("fp_still_pending", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("fp_byte", 32'(out_byte), 32'h30);
        check("fp_pad", 32'(out_padded), 32'd1);
        check("fp_cnt_mid", 32'(cnt), 32'd5);
        tick();
        check("fp_cnt", 32'(cnt), 32'd6);
        check("fp_empty_ready", 32'(in_ready), 32'd1);
        check("fp_drained", 32'(out_valid), 32'd0);

        // Flush while EMPTY is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fe_ignored", 32'(out_valid), 32'd0);

        // Flush coincident with completing transfer is ignored
        send(4'h7);
        flush = 1'b1;
        send(4'h8);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fx_byte", 32'(out_byte), 32'h78);
        check("fx_pad", 32'(out_padded), 32'd0);
        tick();
        check("fx_cnt", 32'(cnt), 32'd7);
        check("fx_c2_cnt", 32'(c2_cnt), 32'd3);

        // Reset in HALF with an undelivered byte
        out_ready = 1'b0;
        send(4'h9);
        send(4'h4);
        send(4'h6);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_byte", 32'(out_byte), 32'h00);
        check("mr_pad", 32'(out_padded), 32'd0);
        check("mr_cnt", 32'(cnt), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mr_no_partial", 32'(out_valid), 32'd0);
        send(4'h1);
        send(4'h2);
        in_valid = 1'b0;
        check("mr_12_byte", 32'(out_byte), 32'h12);
        check("mr_12_pad", 32'(out_padded), 32'd0);
        tick();
        check("mr_12_cnt", 32'(cnt), 32'd1);
        tick();
        check("mr_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
